// File: rtl/sat_accum_stage.sv
// Block accumulator: sums len signed samples with per-beat saturation and holds the result until taken.
// Optional macro SAT_ACCUM_FLAG_EN adds the sticky out_sat flag.
module sat_accum_stage #(
    parameter int BITWIDTH = 32,
    parameter int COUNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITWIDTH-1:0] in_data,
    input  logic [COUNT_W-1:0]  len,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITWIDTH-1:0] out_data
`ifdef SAT_ACCUM_FLAG_EN
    ,
    output logic                out_sat
`endif
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t              state, state_nx;
    logic [BITWIDTH-1:0] acc;
    logic [COUNT_W-1:0]  rem;
    logic [COUNT_W-1:0]  first_rem;
    logic                beat;
    logic [BITWIDTH:0]   sum;
    logic [BITWIDTH-1:0] sat_sum;
    logic                clamp;

    assign beat      = in_valid && in_ready;
    assign first_rem = (len == '0) ? '0 : len - COUNT_W'(1);
    assign sum       = {acc[BITWIDTH-1], acc} + {in_data[BITWIDTH-1], in_data};

    // Top two bits of the widened sum disagree only on overflow.
    always_comb begin
        clamp   = 1'b0;
        sat_sum = sum[BITWIDTH-1:0];
        case (sum[BITWIDTH:BITWIDTH-1])
            2'b01: begin
                clamp   = 1'b1;
                sat_sum = {1'b0, {(BITWIDTH-1){1'b1}}};
            end
            2'b10: begin
                clamp   = 1'b1;
                sat_sum = {1'b1, {(BITWIDTH-1){1'b0}}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (beat) state_nx = (first_rem == '0) ? HOLD : ACCUM;
            ACCUM:   if (beat && rem == COUNT_W'(1)) state_nx = HOLD;
            HOLD:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state != HOLD);
        out_valid = (state == HOLD);
    end

    // out_data is a separate register so the result survives the next block's first beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            rem      <= '0;
            out_data <= '0;
        end else if (beat && state == IDLE) begin
            acc <= in_data;
            rem <= first_rem;
            if (first_rem == '0) out_data <= in_data;
        end else if (beat && state == ACCUM) begin
            acc <= sat_sum;
            rem <= rem - COUNT_W'(1);
            if (rem == COUNT_W'(1)) out_data <= sat_sum;
        end
    end

`ifdef SAT_ACCUM_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        out_sat <= 1'b0;
        else if (beat && state == IDLE)    out_sat <= 1'b0;
        else if (beat && state == ACCUM && clamp) out_sat <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_sat_accum_stage.sv
// Directed plus randomized bench for sat_accum_stage against a plain-arithmetic block-sum model.
module tb_sat_accum_stage;
    localparam int W  = 32;
    localparam int CW = 8;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [CW-1:0] len;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
`ifdef SAT_ACCUM_FLAG_EN
    logic          out_sat;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] dq[$];

    always #5 clk = ~clk;

    sat_accum_stage #(.BITWIDTH(W), .COUNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .len(len),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef SAT_ACCUM_FLAG_EN
        , .out_sat(out_sat)
`endif
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_sat(input string tag, input logic exp);
`ifdef SAT_ACCUM_FLAG_EN
        chk(tag, {31'd0, out_sat}, {31'd0, exp});
`endif
    endtask

    // Reference: running signed sum clamped to the 32-bit range after every add.
    task automatic model(output logic [W-1:0] res, output logic sat);
        longint a;
        a   = longint'($signed(dq[0]));
        sat = 1'b0;
        for (int i = 1; i < dq.size(); i++) begin
            a = a + longint'($signed(dq[i]));
            if (a > MAXV) begin a = MAXV; sat = 1'b1; end
            else if (a < MINV) begin a = MINV; sat = 1'b1; end
        end
        res = a[W-1:0];
    endtask

    // Called at a negedge; samples in dq, l is the len presented on the first beat.
    task automatic run_block(input string tag, input int l, input logic [W-1:0] exp,
                             input logic exp_sat, input int hold_cyc, input bit bubbles);
        for (int i = 0; i < dq.size(); i++) begin
            if (bubbles && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                len      = CW'($urandom);
                @(negedge clk);
            end
            chk({tag, ":rdy"}, {31'd0, in_ready}, 32'd1);
            chk({tag, ":ov_lo"}, {31'd0, out_valid}, 32'd0);
            in_valid = 1'b1;
            in_data  = dq[i];
            len      = (i == 0) ? CW'(l) : CW'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk({tag, ":ov"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ":data"}, out_data, exp);
        chk_sat({tag, ":sat"}, exp_sat);
        in_valid = 1'b1;
        in_data  = $urandom;
        out_ready = 1'b0;
        for (int c = 0; c < hold_cyc; c++) begin
            @(negedge clk);
            chk({tag, ":hold_rdy"}, {31'd0, in_ready}, 32'd0);
            chk({tag, ":hold_data"}, out_data, exp);
            chk_sat({tag, ":hold_sat"}, exp_sat);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ":ov_clr"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ":idle_rdy"}, {31'd0, in_ready}, 32'd1);
        chk({tag, ":keep"}, out_data, exp);
    endtask

    initial begin
        logic [W-1:0] r;
        logic         s;
        int           n;
        int           l;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; len = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ov", {31'd0, out_valid}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_rdy", {31'd0, in_ready}, 32'd1);
        chk_sat("rst_sat", 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        dq = '{32'd1, 32'd2, 32'd3};
        run_block("sum6", 3, 32'd6, 1'b0, 0, 1'b0);
        dq = '{32'h7FFFFFF0, 32'h00000020};
        run_block("pos_sat", 2, 32'h7FFFFFFF, 1'b1, 1, 1'b0);
        dq = '{32'h80000001, 32'hFFFFFFF0, 32'h00000005};
        run_block("neg_sat", 3, 32'h80000005, 1'b1, 0, 1'b0);
        dq = '{32'h12345678};
        run_block("len0", 0, 32'h12345678, 1'b0, 0, 1'b0);
        dq = '{32'd10, 32'hFFFFFFFD};
        run_block("stall", 2, 32'd7, 1'b0, 5, 1'b0);

        // Reset during ACCUM after 2 of 4 beats.
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 32'd100 + 32'(i);
            len      = CW'(4);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("arst_ov", {31'd0, out_valid}, 32'd0);
        chk("arst_data", out_data, 32'd0);
        chk("arst_rdy", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        dq = '{32'd7};
        run_block("post_rst", 1, 32'd7, 1'b0, 0, 1'b0);

        for (int b = 0; b < 25; b++) begin
            l = $urandom_range(0, 6);
            n = (l == 0) ? 1 : l;
            dq = {};
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 2))
                    0: dq.push_back(32'h7FFF0000 | 32'($urandom_range(0, 65535)));
                    1: dq.push_back(32'h80000000 | 32'($urandom_range(0, 65535)));
                    default: dq.push_back($urandom);
                endcase
            end
            model(r, s);
            run_block("rand", l, r, s, $urandom_range(0, 3), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sat_accum_stage.md
SAT_ACCUM_STAGE -- requirements
Module: sat_accum_stage

Interface
REQ-001 SHALL have parameter BITWIDTH, default 32, giving the two's-complement sample and sum width.
REQ-002 SHALL have parameter COUNT_W, default 8, giving the width of the block-length field.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit, meaning a sample is offered.
REQ-006 SHALL have port in_ready, output, 1 bit, meaning the stage accepts a sample this cycle.
REQ-007 SHALL have port in_data, input, BITWIDTH bits, the signed sample.
REQ-008 SHALL have port len, input, COUNT_W bits, the number of samples in the block; it is sampled on the block's first accepted beat.
REQ-009 SHALL have port out_valid, output, 1 bit, meaning the block result is available.
REQ-010 SHALL have port out_ready, input, 1 bit, meaning downstream accepts the result.
REQ-011 SHALL have port out_data, output, BITWIDTH bits, the saturated signed block sum.
REQ-012 SHALL have port out_sat, output, 1 bit, meaning saturation occurred in the block; it is present only under SAT_ACCUM_FLAG_EN.

Function
REQ-013 SHALL implement the FSM states IDLE, ACCUM and HOLD.
REQ-014 SHALL define a beat as in_valid && in_ready; in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD.
REQ-015 SHALL, on a beat in IDLE, load acc = in_data and remaining = len-1, treating len==0 as len==1.
REQ-016 SHALL then go to HOLD if remaining==0, else to ACCUM.
REQ-017 SHALL, on a beat in ACCUM, set acc = sat(acc + in_data) and decrement remaining; on the beat where remaining==1 it SHALL go to HOLD.
REQ-018 SHALL compute sat() by sign-extending both operands to BITWIDTH+1 bits and adding.
REQ-019 SHALL clamp a sum whose top two bits are 01 to 0 followed by all ones (max positive).
REQ-020 SHALL clamp a sum whose top two bits are 10 to 1 followed by all zeros (min negative).
REQ-021 SHALL otherwise take the low BITWIDTH bits of the sum.
REQ-022 SHALL apply each saturation immediately to acc; later samples continue from the clamped value, with no wrap-around.
REQ-023 SHALL leave state and registers unchanged in IDLE and ACCUM when in_valid is 0; bubbles are allowed.
REQ-024 SHALL assert out_valid in HOLD with out_data = acc, exactly 1 cycle after the final beat.
REQ-025 SHALL hold out_valid, out_data and out_sat stable in HOLD until out_valid && out_ready.
REQ-026 SHALL, on out_valid && out_ready, go to IDLE, clear out_valid and accept a new block from the next cycle.
REQ-027 SHALL ignore len except on the first beat of a block.
REQ-028 SHALL drive out_data with the last result after HOLD exits until the next result.

Reset
REQ-029 SHALL, while rst_n is 0, force state to IDLE and set acc, remaining, out_valid, out_data and out_sat to 0, regardless of clk.
REQ-030 SHALL, on reset during ACCUM or HOLD, discard the partial block and pending result; the first beat after release SHALL start a new block.

Configuration
REQ-031 SHALL, when macro SAT_ACCUM_FLAG_EN is defined, provide out_sat as a sticky flag.
REQ-032 SHALL clear that flag on the first beat of a block and set it on any clamping in the block.
REQ-033 SHALL present that flag with out_data under the same stability rule.
REQ-034 SHALL, when SAT_ACCUM_FLAG_EN is undefined, omit the out_sat port and its register, with all other behaviour identical.

Verification
REQ-035 SHALL cover: len=3, data 1,2,3 on consecutive cycles -> out_valid=1 with out_data=6 one cycle after the third beat, out_sat=0.
REQ-036 SHALL cover: len=2, data 0x7FFFFFF0 then 0x00000020 -> out_data=0x7FFFFFFF, out_sat=1.
REQ-037 SHALL cover: len=3, data 0x80000001, 0xFFFFFFF0, 0x00000005 -> out_data=0x80000005, out_sat=1.
REQ-038 SHALL cover: len=0, data 0x12345678 -> treated as len=1, out_data=0x12345678 one cycle after the beat.
REQ-039 SHALL cover: result pending with out_ready=0 for 5 cycles and in_valid=1 -> in_ready=0, out_data stable, no sample consumed; out_ready=1 -> IDLE next cycle.
REQ-040 SHALL cover: rst_n pulsed low mid-ACCUM after 2 of 4 beats -> out_valid=0, out_data=0, state IDLE; a new len=1 block of 7 -> out_data=7.
